// File: rtl/list_pkg.sv
// Shared types and default widths for the list engine and its scan datapath.
package list_pkg;

  localparam int DEFAULT_DATA_WIDTH   = 32;
  localparam int DEFAULT_LENGTH       = 8;
  localparam int DEFAULT_LENGTH_WIDTH = 16;

  typedef enum logic [2:0] {
    OP_READ   = 3'd0,
    OP_INSERT = 3'd1,
    OP_DELETE = 3'd2,
    OP_FIND   = 3'd3,
    OP_SUM    = 3'd4,
    OP_CLEAR  = 3'd6
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    INS_SHIFT,
    DEL_SHIFT,
    SCAN,
    ACCUM,
    RESP
  } state_e;

  typedef enum logic {
    SCAN_FIND = 1'b0,
    SCAN_SUM  = 1'b1
  } scan_mode_e;

endpackage

// File: rtl/list_scan_unit.sv
// Pointer walk over entries 0..len-1 with one compare/accumulate per cycle,
// shared by FIND and SUM. The parent supplies the entry addressed by index.
module list_scan_unit
  import list_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int LENGTH_WIDTH = DEFAULT_LENGTH_WIDTH,
  parameter int CNT_WIDTH    = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  scan_mode_e                         mode,
  input  logic [CNT_WIDTH-1:0]               len,
  input  logic [DATA_WIDTH-1:0]              key,
  input  logic [DATA_WIDTH-1:0]              entry,
  output logic                               hit,
  output logic [CNT_WIDTH-1:0]               index,
  output logic [LENGTH_WIDTH+DATA_WIDTH-1:0] sum,
  output logic                               finished
);

  localparam int SUM_WIDTH = LENGTH_WIDTH + DATA_WIDTH;

  logic                 busy_reg;
  scan_mode_e           mode_reg;
  logic [CNT_WIDTH-1:0] ptr_reg;
  logic [SUM_WIDTH-1:0] acc_reg;

  assign index    = ptr_reg;
  assign hit      = busy_reg && (mode_reg == SCAN_FIND) && (entry == key);
  // sum already includes the current entry so the final value is ready on finished
  assign sum      = acc_reg + SUM_WIDTH'(entry);
  assign finished = busy_reg && (hit || ((ptr_reg + CNT_WIDTH'(1)) == len));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_reg <= 1'b0;
      mode_reg <= SCAN_FIND;
      ptr_reg  <= '0;
      acc_reg  <= '0;
    end else if (start) begin
      busy_reg <= 1'b1;
      mode_reg <= mode;
      ptr_reg  <= '0;
      acc_reg  <= '0;
    end else if (busy_reg) begin
      acc_reg <= sum;
      ptr_reg <= ptr_reg + CNT_WIDTH'(1);
      if (finished) begin
        busy_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/list_engine.sv
// Responder for the op_sel/op_en list protocol: register-array storage with
// multi-cycle shifting, plus FIND/SUM via list_scan_unit. LIST_CLEAR_OP_EN adds CLEAR (opcode 6).
module list_engine
  import list_pkg::*;
#(
  parameter  int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter  int LENGTH       = DEFAULT_LENGTH,
  parameter  int LENGTH_WIDTH = DEFAULT_LENGTH_WIDTH,
  localparam int CNT_WIDTH    = $clog2(LENGTH + 1)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [2:0]                         op_sel,
  input  logic                               op_en,
  input  logic [DATA_WIDTH-1:0]              data_in,
  input  logic [LENGTH_WIDTH-1:0]            index_in,
  output logic [LENGTH_WIDTH+DATA_WIDTH-1:0] data_out,
  output logic                               op_done,
  output logic                               op_in_progress,
  output logic                               op_error,
  output logic [CNT_WIDTH-1:0]               len
);

  localparam int                   OUT_WIDTH  = LENGTH_WIDTH + DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LENGTH_CNT = CNT_WIDTH'(LENGTH);

  state_e                state_reg, state_next;
  logic [CNT_WIDTH-1:0]  ptr_reg, ptr_next;
  logic [CNT_WIDTH-1:0]  cmd_index_reg, cmd_index_next;
  logic [DATA_WIDTH-1:0] cmd_data_reg, cmd_data_next;
  logic [CNT_WIDTH-1:0]  len_reg, len_next;
  logic [OUT_WIDTH-1:0]  data_out_reg, data_out_next;
  logic                  op_done_reg, op_done_next;
  logic                  op_error_reg, op_error_next;
  logic                  op_in_progress_reg;

  logic [DATA_WIDTH-1:0] entries_reg [LENGTH];

  logic                  write_en;
  logic [CNT_WIDTH-1:0]  write_idx;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  zero_en;
  logic [CNT_WIDTH-1:0]  zero_idx;
  logic                  shift_up;
  logic                  shift_down;
`ifdef LIST_CLEAR_OP_EN
  logic                  clear_en;
`endif

  logic                  scan_start;
  scan_mode_e            scan_mode;
  logic                  scan_hit;
  logic [CNT_WIDTH-1:0]  scan_index;
  logic [OUT_WIDTH-1:0]  scan_sum;
  logic                  scan_finished;

  logic [DATA_WIDTH-1:0]   read_entry;
  logic [DATA_WIDTH-1:0]   scan_entry;
  logic [LENGTH_WIDTH-1:0] len_wide;
  logic [CNT_WIDTH-1:0]    idx_short;
  logic                    idx_lt_len;
  logic                    idx_le_len;

  // Range checks use the full index width so out-of-range indices never alias.
  assign len_wide   = LENGTH_WIDTH'(len_reg);
  assign idx_short  = CNT_WIDTH'(index_in);
  assign idx_lt_len = index_in < len_wide;
  assign idx_le_len = index_in <= len_wide;

  always_comb begin
    read_entry = '0;
    scan_entry = '0;
    for (int i = 0; i < LENGTH; i++) begin
      if (index_in == LENGTH_WIDTH'(i)) read_entry = entries_reg[i];
      if (scan_index == CNT_WIDTH'(i)) scan_entry = entries_reg[i];
    end
  end

  list_scan_unit #(
    .DATA_WIDTH  (DATA_WIDTH),
    .LENGTH_WIDTH(LENGTH_WIDTH),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_scan (
    .clk     (clk),
    .rst     (rst),
    .start   (scan_start),
    .mode    (scan_mode),
    .len     (len_reg),
    .key     (cmd_data_reg),
    .entry   (scan_entry),
    .hit     (scan_hit),
    .index   (scan_index),
    .sum     (scan_sum),
    .finished(scan_finished)
  );

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    cmd_index_next = cmd_index_reg;
    cmd_data_next  = cmd_data_reg;
    len_next       = len_reg;
    data_out_next  = data_out_reg;
    op_error_next  = 1'b0;
    write_en       = 1'b0;
    write_idx      = '0;
    write_data     = '0;
    zero_en        = 1'b0;
    zero_idx       = '0;
    shift_up       = 1'b0;
    shift_down     = 1'b0;
`ifdef LIST_CLEAR_OP_EN
    clear_en       = 1'b0;
`endif
    scan_start     = 1'b0;
    scan_mode      = SCAN_FIND;

    case (state_reg)
      IDLE: begin
        if (op_en) begin
          cmd_index_next = idx_short;
          cmd_data_next  = data_in;
          state_next     = RESP;
          op_error_next  = 1'b1;
          case (op_e'(op_sel))
            OP_READ: begin
              if (idx_lt_len) begin
                op_error_next = 1'b0;
                data_out_next = {{LENGTH_WIDTH{1'b0}}, read_entry};
              end
            end
            OP_INSERT: begin
              if ((len_reg < LENGTH_CNT) && idx_le_len) begin
                op_error_next = 1'b0;
                if (idx_short == len_reg) begin
                  // appending needs no shift: write now and respond next cycle
                  write_en      = 1'b1;
                  write_idx     = idx_short;
                  write_data    = data_in;
                  len_next      = len_reg + CNT_WIDTH'(1);
                  data_out_next = OUT_WIDTH'(len_reg + CNT_WIDTH'(1));
                end else begin
                  ptr_next   = len_reg;
                  state_next = INS_SHIFT;
                end
              end
            end
            OP_DELETE: begin
              if (idx_lt_len) begin
                op_error_next = 1'b0;
                if ((idx_short + CNT_WIDTH'(1)) == len_reg) begin
                  zero_en       = 1'b1;
                  zero_idx      = idx_short;
                  len_next      = len_reg - CNT_WIDTH'(1);
                  data_out_next = OUT_WIDTH'(len_reg - CNT_WIDTH'(1));
                end else begin
                  ptr_next   = idx_short;
                  state_next = DEL_SHIFT;
                end
              end
            end
            OP_FIND: begin
              if (len_reg != '0) begin
                op_error_next = 1'b0;
                scan_start    = 1'b1;
                scan_mode     = SCAN_FIND;
                state_next    = SCAN;
              end
            end
            OP_SUM: begin
              op_error_next = 1'b0;
              if (len_reg == '0) begin
                data_out_next = '0;
              end else begin
                scan_start = 1'b1;
                scan_mode  = SCAN_SUM;
                state_next = ACCUM;
              end
            end
`ifdef LIST_CLEAR_OP_EN
            OP_CLEAR: begin
              op_error_next = 1'b0;
              clear_en      = 1'b1;
              len_next      = '0;
              data_out_next = '0;
            end
`endif
            default: ;
          endcase
        end
      end
      INS_SHIFT: begin
        // ptr is the destination slot; the slot below it moves up
        shift_up = 1'b1;
        ptr_next = ptr_reg - CNT_WIDTH'(1);
        if (ptr_reg == (cmd_index_reg + CNT_WIDTH'(1))) begin
          write_en      = 1'b1;
          write_idx     = cmd_index_reg;
          write_data    = cmd_data_reg;
          len_next      = len_reg + CNT_WIDTH'(1);
          data_out_next = OUT_WIDTH'(len_reg + CNT_WIDTH'(1));
          state_next    = RESP;
        end
      end
      DEL_SHIFT: begin
        shift_down = 1'b1;
        ptr_next   = ptr_reg + CNT_WIDTH'(1);
        if ((ptr_reg + CNT_WIDTH'(2)) == len_reg) begin
          zero_en       = 1'b1;
          zero_idx      = ptr_reg + CNT_WIDTH'(1);
          len_next      = len_reg - CNT_WIDTH'(1);
          data_out_next = OUT_WIDTH'(len_reg - CNT_WIDTH'(1));
          state_next    = RESP;
        end
      end
      SCAN: begin
        if (scan_finished) begin
          state_next = RESP;
          if (scan_hit) begin
            data_out_next = OUT_WIDTH'(scan_index);
          end else begin
            op_error_next = 1'b1;
          end
        end
      end
      ACCUM: begin
        if (scan_finished) begin
          data_out_next = scan_sum;
          state_next    = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    op_done_next = (state_next == RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg          <= IDLE;
      ptr_reg            <= '0;
      cmd_index_reg      <= '0;
      cmd_data_reg       <= '0;
      len_reg            <= '0;
      data_out_reg       <= '0;
      op_done_reg        <= 1'b0;
      op_error_reg       <= 1'b0;
      op_in_progress_reg <= 1'b0;
    end else begin
      state_reg          <= state_next;
      ptr_reg            <= ptr_next;
      cmd_index_reg      <= cmd_index_next;
      cmd_data_reg       <= cmd_data_next;
      len_reg            <= len_next;
      data_out_reg       <= data_out_next;
      op_done_reg        <= op_done_next;
      op_error_reg       <= op_error_next;
      op_in_progress_reg <= (state_next != IDLE);
    end
  end

  for (genvar gi = 0; gi < LENGTH; gi++) begin : g_entry
    localparam logic [CNT_WIDTH-1:0] SLOT = CNT_WIDTH'(gi);
    logic [DATA_WIDTH-1:0] below;
    logic [DATA_WIDTH-1:0] above;
    logic [DATA_WIDTH-1:0] entry_next;

    if (gi > 0) begin : g_below
      assign below = entries_reg[gi-1];
    end else begin : g_no_below
      assign below = '0;
    end

    if (gi < LENGTH - 1) begin : g_above
      assign above = entries_reg[gi+1];
    end else begin : g_no_above
      assign above = '0;
    end

    always_comb begin
      entry_next = entries_reg[gi];
      if (write_en && (write_idx == SLOT)) begin
        entry_next = write_data;
      end else if (zero_en && (zero_idx == SLOT)) begin
        entry_next = '0;
      end else if (shift_up && (ptr_reg == SLOT)) begin
        entry_next = below;
      end else if (shift_down && (ptr_reg == SLOT)) begin
        entry_next = above;
      end
`ifdef LIST_CLEAR_OP_EN
      if (clear_en) begin
        entry_next = '0;
      end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        entries_reg[gi] <= '0;
      end else begin
        entries_reg[gi] <= entry_next;
      end
    end
  end

  assign data_out       = data_out_reg;
  assign op_done        = op_done_reg;
  assign op_in_progress = op_in_progress_reg;
  assign op_error       = op_error_reg;
  assign len            = len_reg;

endmodule
